// File: rtl/fft_seq_pkg.sv
// fft_seq_pkg: shared types and defaults for the FFT frame sequencer.
//   bank_state_e : lifecycle of one ping-pong frame bank
//   rd_state_e   : reader FSM states
//   DATA_W_DEF / PTS_W_DEF : default sample width and fft_pts width
package fft_seq_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int PTS_W_DEF  = 14;

    typedef enum logic [1:0] {
        BANK_EMPTY    = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_state_e;

    typedef enum logic {
        R_IDLE   = 1'b0,
        R_STREAM = 1'b1
    } rd_state_e;

endpackage

// File: rtl/fft_seq_bank_ram.sv
// fft_seq_bank_ram: simple dual-port RAM holding both frame banks.
// Address is {bank, idx}; read data is registered (1-cycle latency).
// Ports:
//   clk      : clock
//   wr_en    : write strobe
//   wr_addr  : {bank, idx} write address
//   wr_data  : sample to store
//   rd_en    : read strobe
//   rd_addr  : {bank, idx} read address
//   rd_data  : registered read data, valid the cycle after rd_en
module fft_seq_bank_ram #(
    parameter int N_PTS  = 1024,
    parameter int LOG2_N = 10,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [LOG2_N:0]   wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [LOG2_N:0]   rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2*N_PTS];
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer: collects audio samples into two ping-pong frame banks
// and streams each complete frame into the FFT sink (Avalon-ST).
// Optional feature macro: FFT_SEQ_DROP_CNT_EN builds the 16-bit saturating
// drop counter; without it drop_count is tied to zero.
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   in_sample, in_valid   : audio sample and its one-cycle strobe
//   enable                : allows a new frame capture to begin
//   sink_valid/ready/sop/eop/real/imag : FFT sink stream
//   fft_pts, inverse      : constant FFT run-time configuration
//   busy                  : some bank is FILLING, FULL or DRAINING
//   overflow, overflow_clr: sticky drop flag and its clear
//   drop_count            : number of dropped samples
//
// Handshake: a word transfers on a rising edge where sink_valid && sink_ready;
// once sink_valid is high the word and its sop/eop are held until it
// transfers, and sink_valid only falls after a transfer.
module fft_frame_sequencer
    import fft_seq_pkg::*;
#(
    parameter int N_PTS  = 1024,
    parameter int LOG2_N = 10,
    parameter int DATA_W = DATA_W_DEF,
    parameter int PTS_W  = PTS_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] in_sample,
    input  logic              in_valid,
    input  logic              enable,
    output logic              sink_valid,
    input  logic              sink_ready,
    output logic              sink_sop,
    output logic              sink_eop,
    output logic [DATA_W-1:0] sink_real,
    output logic [DATA_W-1:0] sink_imag,
    output logic [PTS_W-1:0]  fft_pts,
    output logic              inverse,
    output logic              busy,
    output logic              overflow,
    input  logic              overflow_clr,
    output logic [15:0]       drop_count
);

    localparam logic [LOG2_N-1:0] LAST_IDX = LOG2_N'(N_PTS - 1);

    // Bank lifecycle and writer state
    bank_state_e       bank_q [2];
    bank_state_e       bank_d [2];
    logic              wr_bank_q, wr_bank_d;
    logic [LOG2_N-1:0] wr_idx_q, wr_idx_d;

    // Reader state
    rd_state_e         rd_state_q, rd_state_d;
    logic              rd_bank_q, rd_bank_d;
    logic [LOG2_N-1:0] rd_idx_q, rd_idx_d;
    logic              issue_done_q, issue_done_d;

    // RAM read in flight (data appears on ram_rd_data this cycle)
    logic              inflight_q, inflight_d;
    logic              inflight_sop_q, inflight_sop_d;
    logic              inflight_eop_q, inflight_eop_d;

    // 2-entry output skid buffer; entry 0 drives the sink
    logic [1:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] e0_data_q, e0_data_d, e1_data_q, e1_data_d;
    logic              e0_sop_q, e0_sop_d, e1_sop_q, e1_sop_d;
    logic              e0_eop_q, e0_eop_d, e1_eop_q, e1_eop_d;

    logic              overflow_q, overflow_d;

    // Control strobes between the writer, reader and bank bookkeeping
    logic              ram_wr_en;
    logic              ram_rd_en;
    logic [DATA_W-1:0] ram_rd_data;
    logic              wr_claim, wr_complete, drop;
    logic              rd_start, rd_release;
    logic              pop, push, space;
    logic [2:0]        occ;

    fft_seq_bank_ram #(
        .N_PTS  (N_PTS),
        .LOG2_N (LOG2_N),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (ram_wr_en),
        .wr_addr ({wr_bank_q, wr_idx_q}),
        .wr_data (in_sample),
        .rd_en   (ram_rd_en),
        .rd_addr ({rd_bank_q, rd_idx_q}),
        .rd_data (ram_rd_data)
    );

    // Writer: wr_idx_q is always 0 while its bank is EMPTY, so the same
    // address path serves both the claiming write and the filling writes.
    always_comb begin
        wr_bank_d   = wr_bank_q;
        wr_idx_d    = wr_idx_q;
        ram_wr_en   = 1'b0;
        wr_claim    = 1'b0;
        wr_complete = 1'b0;
        drop        = 1'b0;
        if (in_valid) begin
            case (bank_q[wr_bank_q])
                BANK_EMPTY: begin
                    if (enable) begin
                        ram_wr_en = 1'b1;
                        wr_claim  = 1'b1;
                        wr_idx_d  = wr_idx_q + 1'b1;
                    end
                end
                BANK_FILLING: begin
                    // A started frame always completes, regardless of enable.
                    ram_wr_en = 1'b1;
                    wr_idx_d  = wr_idx_q + 1'b1;
                    if (wr_idx_q == LAST_IDX) begin
                        wr_complete = 1'b1;
                        wr_bank_d   = ~wr_bank_q;
                    end
                end
                default: begin
                    drop = enable;
                end
            endcase
        end
    end

    // Output buffer occupancy bookkeeping
    assign sink_valid = (cnt_q != 2'd0);
    assign pop        = sink_valid && sink_ready;
    assign push       = inflight_q;
    // Issue a read only if buffered + in-flight words, after this cycle's
    // pop, leave a free slot for the returning word.
    assign occ        = 3'(cnt_q) + 3'(inflight_q);
    assign space      = (occ <= (3'd1 + 3'(pop)));

    // Reader FSM: next state and read issue
    always_comb begin
        rd_state_d     = rd_state_q;
        rd_bank_d      = rd_bank_q;
        rd_idx_d       = rd_idx_q;
        issue_done_d   = issue_done_q;
        ram_rd_en      = 1'b0;
        inflight_sop_d = 1'b0;
        inflight_eop_d = 1'b0;
        rd_start       = 1'b0;
        rd_release     = 1'b0;
        case (rd_state_q)
            R_IDLE: begin
                // Buffer and pipeline are empty here, so word 0 is fetched
                // in the same cycle the bank is claimed.
                if (bank_q[rd_bank_q] == BANK_FULL) begin
                    rd_start       = 1'b1;
                    rd_state_d     = R_STREAM;
                    ram_rd_en      = 1'b1;
                    inflight_sop_d = 1'b1;
                    rd_idx_d       = rd_idx_q + 1'b1;
                    issue_done_d   = 1'b0;
                end
            end
            R_STREAM: begin
                if (!issue_done_q && space) begin
                    ram_rd_en      = 1'b1;
                    inflight_eop_d = (rd_idx_q == LAST_IDX);
                    rd_idx_d       = rd_idx_q + 1'b1;
                    if (rd_idx_q == LAST_IDX) begin
                        issue_done_d = 1'b1;
                    end
                end
                // The bank is released only when its last word leaves the sink.
                if (pop && e0_eop_q) begin
                    rd_release   = 1'b1;
                    rd_bank_d    = ~rd_bank_q;
                    rd_state_d   = R_IDLE;
                    issue_done_d = 1'b0;
                end
            end
            default: begin
                rd_state_d = R_IDLE;
            end
        endcase
        inflight_d = ram_rd_en;
    end

    // Bank states; writer and reader never act on the same bank in one cycle
    // because they require different current states.
    always_comb begin
        bank_d = bank_q;
        if (wr_claim) begin
            bank_d[wr_bank_q] = BANK_FILLING;
        end
        if (wr_complete) begin
            bank_d[wr_bank_q] = BANK_FULL;
        end
        if (rd_start) begin
            bank_d[rd_bank_q] = BANK_DRAINING;
        end
        if (rd_release) begin
            bank_d[rd_bank_q] = BANK_EMPTY;
        end
    end

    // Skid buffer: entry 0 only changes when it is popped or empty, which
    // keeps the presented word stable under backpressure.
    always_comb begin
        cnt_d     = cnt_q;
        e0_data_d = e0_data_q;
        e0_sop_d  = e0_sop_q;
        e0_eop_d  = e0_eop_q;
        e1_data_d = e1_data_q;
        e1_sop_d  = e1_sop_q;
        e1_eop_d  = e1_eop_q;
        case ({push, pop})
            2'b01: begin
                e0_data_d = e1_data_q;
                e0_sop_d  = e1_sop_q;
                e0_eop_d  = e1_eop_q;
                cnt_d     = cnt_q - 2'd1;
            end
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    e0_data_d = ram_rd_data;
                    e0_sop_d  = inflight_sop_q;
                    e0_eop_d  = inflight_eop_q;
                end else begin
                    e1_data_d = ram_rd_data;
                    e1_sop_d  = inflight_sop_q;
                    e1_eop_d  = inflight_eop_q;
                end
                cnt_d = cnt_q + 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    e0_data_d = ram_rd_data;
                    e0_sop_d  = inflight_sop_q;
                    e0_eop_d  = inflight_eop_q;
                end else begin
                    e0_data_d = e1_data_q;
                    e0_sop_d  = e1_sop_q;
                    e0_eop_d  = e1_eop_q;
                    e1_data_d = ram_rd_data;
                    e1_sop_d  = inflight_sop_q;
                    e1_eop_d  = inflight_eop_q;
                end
            end
            default: begin
            end
        endcase
    end

    // Sticky overflow: a drop in the same cycle as a clear wins.
    always_comb begin
        overflow_d = overflow_q;
        if (overflow_clr) begin
            overflow_d = 1'b0;
        end
        if (drop) begin
            overflow_d = 1'b1;
        end
    end

`ifdef FFT_SEQ_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (overflow_clr) begin
            drop_cnt_d = 16'd0;
        end
        if (drop && (drop_cnt_d != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_d + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt_q <= 16'd0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_count = drop_cnt_q;
`else
    assign drop_count = 16'd0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bank_q[0]      <= BANK_EMPTY;
            bank_q[1]      <= BANK_EMPTY;
            wr_bank_q      <= 1'b0;
            wr_idx_q       <= '0;
            rd_state_q     <= R_IDLE;
            rd_bank_q      <= 1'b0;
            rd_idx_q       <= '0;
            issue_done_q   <= 1'b0;
            inflight_q     <= 1'b0;
            inflight_sop_q <= 1'b0;
            inflight_eop_q <= 1'b0;
            cnt_q          <= 2'd0;
            e0_data_q      <= '0;
            e0_sop_q       <= 1'b0;
            e0_eop_q       <= 1'b0;
            e1_data_q      <= '0;
            e1_sop_q       <= 1'b0;
            e1_eop_q       <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            bank_q         <= bank_d;
            wr_bank_q      <= wr_bank_d;
            wr_idx_q       <= wr_idx_d;
            rd_state_q     <= rd_state_d;
            rd_bank_q      <= rd_bank_d;
            rd_idx_q       <= rd_idx_d;
            issue_done_q   <= issue_done_d;
            inflight_q     <= inflight_d;
            inflight_sop_q <= inflight_sop_d;
            inflight_eop_q <= inflight_eop_d;
            cnt_q          <= cnt_d;
            e0_data_q      <= e0_data_d;
            e0_sop_q       <= e0_sop_d;
            e0_eop_q       <= e0_eop_d;
            e1_data_q      <= e1_data_d;
            e1_sop_q       <= e1_sop_d;
            e1_eop_q       <= e1_eop_d;
            overflow_q     <= overflow_d;
        end
    end

    // Stale flags in an emptied entry 0 must not show on the sink.
    assign sink_sop  = sink_valid && e0_sop_q;
    assign sink_eop  = sink_valid && e0_eop_q;
    assign sink_real = e0_data_q;
    assign sink_imag = '0;
    assign fft_pts   = PTS_W'(N_PTS);
    assign inverse   = 1'b0;
    assign busy      = (bank_q[0] != BANK_EMPTY) || (bank_q[1] != BANK_EMPTY);
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// tb_fft_frame_sequencer: randomized bench for fft_frame_sequencer with a
// frame-level reference model and a scoreboard queue of expected sink words.
module tb_fft_frame_sequencer;

    localparam int N  = 1024;
    localparam int DW = 16;
    localparam int PW = 14;
`ifdef FFT_SEQ_DROP_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [DW-1:0] in_sample = '0;
    logic          in_valid = 1'b0;
    logic          enable = 1'b0;
    logic          sink_ready = 1'b0;
    logic          overflow_clr = 1'b0;
    logic          sink_valid, sink_sop, sink_eop, inverse, busy, overflow;
    logic [DW-1:0] sink_real, sink_imag;
    logic [PW-1:0] fft_pts;
    logic [15:0]   drop_count;

    always #5 clk = ~clk;

    fft_frame_sequencer #(
        .N_PTS (N), .LOG2_N (10), .DATA_W (DW), .PTS_W (PW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_sample    (in_sample),
        .in_valid     (in_valid),
        .enable       (enable),
        .sink_valid   (sink_valid),
        .sink_ready   (sink_ready),
        .sink_sop     (sink_sop),
        .sink_eop     (sink_eop),
        .sink_real    (sink_real),
        .sink_imag    (sink_imag),
        .fft_pts      (fft_pts),
        .inverse      (inverse),
        .busy         (busy),
        .overflow     (overflow),
        .overflow_clr (overflow_clr),
        .drop_count   (drop_count)
    );

    int total = 0;
    int bad = 0;

    // Scoreboard entries: {sop, eop, data}
    logic [DW+1:0] exp_q[$];

    // Reference model: frames are whole arrays; a bank is free unless two
    // completed frames are still waiting for or undergoing readout.
    logic [DW-1:0] m_frame[$];
    bit            m_filling = 1'b0;
    int            m_held = 0;
    bit            m_ovf = 1'b0;
    int            m_drops = 0;

    int            xfer_cnt = 0;
    bit            check_gap = 1'b0;
    int            ready_mode = 0;
    int            cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_drops();
        return CNT_EN ? 16'(m_drops) : 16'd0;
    endfunction

    // Advance one clock; inputs change 1 time unit after the rising edge.
    task automatic step();
        logic [3:0] pat;
        pat = 4'b1001;
        @(posedge clk);
        #1;
        cyc++;
        case (ready_mode)
            0: sink_ready = 1'b1;
            1: sink_ready = pat[3 - (cyc % 4)];
            2: sink_ready = 1'b0;
            default: sink_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || busy || sink_valid) && k < budget) begin
            step();
            k++;
        end
        total++;
        if (k >= budget) begin
            bad++;
            $display("FAIL %s: drain timeout, %0d words still expected", name, exp_q.size());
        end
    endtask

    // Reference model, evaluated on the inputs and handshake that the next
    // rising edge will act on.
    initial forever begin
        @(negedge clk);
        if (!reset_n) begin
            m_frame.delete();
            m_filling = 1'b0;
            m_held = 0;
            m_ovf = 1'b0;
            m_drops = 0;
            exp_q.delete();
        end else begin
            if (overflow_clr) begin
                m_ovf = 1'b0;
                m_drops = 0;
            end
            if (in_valid) begin
                if (m_filling) begin
                    m_frame.push_back(in_sample);
                    if (m_frame.size() == N) begin
                        for (int i = 0; i < N; i++) begin
                            exp_q.push_back({(i == 0), (i == N - 1), m_frame[i]});
                        end
                        m_frame.delete();
                        m_filling = 1'b0;
                        m_held++;
                    end
                end else if (enable) begin
                    if (m_held < 2) begin
                        m_filling = 1'b1;
                        m_frame.push_back(in_sample);
                    end else begin
                        m_ovf = 1'b1;
                        if (m_drops < 65535) m_drops++;
                    end
                end
            end
            if (sink_valid && sink_ready && sink_eop) m_held--;
        end
    end

    // Monitor: pops and compares on every transfer; also checks hold-under-
    // backpressure and the idle gap between back-to-back frames.
    initial begin
        bit            prev_hold;
        logic [DW+1:0] prev_word;
        logic [DW+1:0] w;
        bit            gap_arm;
        int            gap_cnt;
        prev_hold = 1'b0;
        prev_word = '0;
        gap_arm = 1'b0;
        gap_cnt = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_hold = 1'b0;
                gap_arm = 1'b0;
            end else begin
                if (prev_hold) begin
                    check("hold_valid", 32'(sink_valid), 32'd1);
                    check("hold_word", 32'({sink_sop, sink_eop, sink_real}), 32'(prev_word));
                end
                if (gap_arm) begin
                    if (sink_valid) begin
                        if (check_gap) check("b2b_gap", gap_cnt, 2);
                        gap_arm = 1'b0;
                    end else begin
                        gap_cnt++;
                    end
                end
                if (sink_valid && sink_ready) begin
                    xfer_cnt++;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_word: got %0h expected none", {sink_sop, sink_eop, sink_real});
                    end else begin
                        w = exp_q.pop_front();
                        check("sink_word", 32'({sink_sop, sink_eop, sink_real}), 32'(w));
                        check("sink_imag", 32'(sink_imag), 32'd0);
                    end
                    if (sink_eop) begin
                        gap_arm = 1'b1;
                        gap_cnt = 0;
                    end
                end
                prev_hold = sink_valid && !sink_ready;
                prev_word = {sink_sop, sink_eop, sink_real};
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int            run;
        int            k;
        int            base;
        logic [15:0]   saved_drops;
        logic [DW-1:0] first;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(sink_valid), 32'd0);
        check("rst_sop", 32'(sink_sop), 32'd0);
        check("rst_eop", 32'(sink_eop), 32'd0);
        check("rst_real", 32'(sink_real), 32'd0);
        check("rst_imag", 32'(sink_imag), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_drop_count", 32'(drop_count), 32'd0);
        check("fft_pts", 32'(fft_pts), N);
        check("inverse", 32'(inverse), 32'd0);
        reset_n = 1'b1;
        enable = 1'b1;
        ready_mode = 0;
        step();

        // Test 1: ramp 0..1023, ready held high; latency and run length
        for (int i = 0; i < N; i++) begin
            in_valid = 1'b1;
            in_sample = DW'(i);
            step();
        end
        in_valid = 1'b0;
        step();
        #1;
        check("t1_valid_lat1", 32'(sink_valid), 32'd0);
        step();
        #1;
        check("t1_valid_lat2", 32'(sink_valid), 32'd1);
        check("t1_first_sop", 32'(sink_sop), 32'd1);
        check("t1_first_real", 32'(sink_real), 32'd0);
        run = 1;
        k = 0;
        while (k < N + 100) begin
            step();
            #1;
            k++;
            if (sink_valid) run++;
            else break;
        end
        check("t1_run_len", run, N);
        wait_idle("t1_drain", 200);

        // Test 2: same ramp, ready pattern 1,0,0,1
        ready_mode = 1;
        for (int i = 0; i < N; i++) begin
            in_valid = 1'b1;
            in_sample = DW'(i);
            step();
        end
        in_valid = 1'b0;
        wait_idle("t2_drain", 3000);

        // Test 3: 3072 continuous random samples, ready low for 2100 cycles
        ready_mode = 2;
        for (int i = 0; i < 3 * N; i++) begin
            in_valid = 1'b1;
            in_sample = DW'($urandom);
            if (i == 2100) ready_mode = 0;
            step();
        end
        in_valid = 1'b0;
        check_gap = 1'b1;
        step();
        #1;
        check("t3_overflow", 32'(overflow), 32'(m_ovf));
        check("t3_overflow_set", 32'(overflow), 32'd1);
        check("t3_drop_model", 32'(drop_count), 32'(exp_drops()));
        check("t3_drop_1024", 32'(drop_count), CNT_EN ? 32'd1024 : 32'd0);
        wait_idle("t3_drain", 3000);
        check_gap = 1'b0;

        // Test 4: enable drops at sample 500; frame completes, rest ignored
        saved_drops = exp_drops();
        for (int i = 0; i < N + 200; i++) begin
            enable = (i < 500);
            in_valid = 1'b1;
            in_sample = DW'($urandom);
            step();
        end
        in_valid = 1'b0;
        step();
        #1;
        check("t4_drop_unchanged", 32'(drop_count), 32'(saved_drops));
        check("t4_busy", 32'(busy), 32'(m_held > 0 || m_filling));
        wait_idle("t4_drain", 2000);
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_sample = DW'($urandom);
            step();
        end
        in_valid = 1'b0;
        step();
        #1;
        check("t4_ignored_busy", 32'(busy), 32'd0);
        check("t4_ignored_valid", 32'(sink_valid), 32'd0);
        enable = 1'b1;

        // Test 5: reset asserted mid-stream around transfer 300
        base = xfer_cnt;
        for (int i = 0; i < N; i++) begin
            in_valid = 1'b1;
            in_sample = DW'($urandom);
            step();
        end
        in_valid = 1'b0;
        k = 0;
        while (xfer_cnt < base + 300 && k < 3000) begin
            step();
            k++;
        end
        check("t5_reach_300", 32'(xfer_cnt >= base + 300), 32'd1);
        reset_n = 1'b0;
        #1;
        check("t5_rst_valid", 32'(sink_valid), 32'd0);
        check("t5_rst_sop", 32'(sink_sop), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_real", 32'(sink_real), 32'd0);
        step();
        step();
        reset_n = 1'b1;
        first = DW'($urandom);
        for (int i = 0; i < N; i++) begin
            in_valid = 1'b1;
            in_sample = (i == 0) ? first : DW'($urandom);
            step();
        end
        in_valid = 1'b0;
        step();
        step();
        #1;
        check("t5_restart_valid", 32'(sink_valid), 32'd1);
        check("t5_restart_sop", 32'(sink_sop), 32'd1);
        check("t5_restart_real", 32'(sink_real), 32'(first));
        wait_idle("t5_drain", 2000);

        // Test 6: clear and drop in the same cycle; set wins
        ready_mode = 2;
        for (int i = 0; i < 2 * N; i++) begin
            in_valid = 1'b1;
            in_sample = DW'($urandom);
            step();
        end
        in_valid = 1'b0;
        step();
        #1;
        check("t6_no_ovf_yet", 32'(overflow), 32'(m_ovf));
        in_valid = 1'b1;
        in_sample = DW'($urandom);
        overflow_clr = 1'b1;
        step();
        in_valid = 1'b0;
        overflow_clr = 1'b0;
        #1;
        check("t6_set_wins", 32'(overflow), 32'd1);
        check("t6_ovf_model", 32'(overflow), 32'(m_ovf));
        check("t6_drop_model", 32'(drop_count), 32'(exp_drops()));
        overflow_clr = 1'b1;
        step();
        overflow_clr = 1'b0;
        #1;
        check("t6_cleared", 32'(overflow), 32'd0);
        check("t6_drop_cleared", 32'(drop_count), 32'(exp_drops()));
        ready_mode = 3;
        wait_idle("t6_drain", 8000);
        check("end_busy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
